// File: rtl/pc_unit.sv
// pc_unit: parametrised program counter for the fetch front end.
// Drives the instruction-memory address (pc) and chip enable (inst_ce).
// Supports stall hold, jump/branch redirect with jump priority, buffering of a
// redirect that arrives while stalled, and target alignment checking.
// Optional feature macro: PC_TRAP_EN adds the trap input and trap redirect.
module pc_unit #(
   parameter int unsigned       WIDTH      = 32,
   parameter int unsigned       STEP       = 4,
   parameter logic [WIDTH-1:0]  RESET_ADDR = '0,
   parameter logic [31:0]       TRAP_ADDR  = 32'h0000_0100
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             stall,
   input  logic             jump,
   input  logic [WIDTH-1:0] jump_target,
   input  logic             branch_taken,
   input  logic [WIDTH-1:0] branch_target,
`ifdef PC_TRAP_EN
   input  logic             trap,
`endif
   output logic [WIDTH-1:0] pc,
   output logic [WIDTH-1:0] pc_seq,
   output logic             inst_ce,
   output logic             misalign_err
);

   // STEP is a power of two, so the low ALIGN bits of a target must be zero
   localparam int unsigned      ALIGN      = $clog2(STEP);
   localparam logic [WIDTH-1:0] ALIGN_MASK = WIDTH'((64'd1 << ALIGN) - 64'd1);
   localparam logic [WIDTH-1:0] STEP_W     = WIDTH'(STEP);

`ifdef PC_TRAP_EN
   localparam logic [WIDTH-1:0] TRAP_W       = WIDTH'(TRAP_ADDR);
   localparam logic [WIDTH-1:0] TRAP_ALIGNED = TRAP_W & ~ALIGN_MASK;
   localparam logic             TRAP_MIS     = |(TRAP_W & ALIGN_MASK);
`else
   logic unused_trap_addr;
   assign unused_trap_addr = ^TRAP_ADDR;
`endif

   logic             pend_valid;
   logic [WIDTH-1:0] pend_target;

   logic             redir;
   logic [WIDTH-1:0] rtgt;
   logic [WIDTH-1:0] rtgt_aligned;
   logic             rtgt_mis;

   logic [WIDTH-1:0] pc_n;
   logic             inst_ce_n;
   logic             misalign_err_n;
   logic             pend_valid_n;
   logic [WIDTH-1:0] pend_target_n;

   // Redirect select: jump wins over branch, then alignment of the chosen target
   assign redir        = jump | branch_taken;
   assign rtgt         = jump ? jump_target : branch_target;
   assign rtgt_aligned = rtgt & ~ALIGN_MASK;
   assign rtgt_mis     = |(rtgt & ALIGN_MASK);

   // Sequential successor, wraps modulo 2^WIDTH
   assign pc_seq = pc + STEP_W;

   // Next-state selection in fixed priority order
   always_comb begin
      pc_n           = pc;
      inst_ce_n      = 1'b1;
      misalign_err_n = 1'b0;
      pend_valid_n   = pend_valid;
      pend_target_n  = pend_target;
      if (!inst_ce) begin
         // boot edge: enable fetch of RESET_ADDR, ignore stall and redirects
         pc_n = pc;
      end
`ifdef PC_TRAP_EN
      else if (trap) begin
         pc_n           = TRAP_ALIGNED;
         pend_valid_n   = 1'b0;
         misalign_err_n = TRAP_MIS;
      end
`endif
      else if (stall && redir) begin
         pend_valid_n   = 1'b1;
         pend_target_n  = rtgt_aligned;
         misalign_err_n = rtgt_mis;
      end
      else if (stall) begin
         pc_n = pc;
      end
      else if (redir) begin
         pc_n           = rtgt_aligned;
         pend_valid_n   = 1'b0;
         misalign_err_n = rtgt_mis;
      end
      else if (pend_valid) begin
         pc_n         = pend_target;
         pend_valid_n = 1'b0;
      end
      else begin
         pc_n = pc_seq;
      end
   end

   // State register with synchronous reset
   always_ff @(posedge clk) begin
      if (reset) begin
         pc           <= RESET_ADDR;
         inst_ce      <= 1'b0;
         misalign_err <= 1'b0;
         pend_valid   <= 1'b0;
         pend_target  <= '0;
      end else begin
         pc           <= pc_n;
         inst_ce      <= inst_ce_n;
         misalign_err <= misalign_err_n;
         pend_valid   <= pend_valid_n;
         pend_target  <= pend_target_n;
      end
   end

endmodule

// File: tb/tb_pc_unit.sv
// Directed testbench for pc_unit: a 32-bit instance for the main features and
// an 8-bit instance for wrap-around and reset-during-stall.
module tb_pc_unit;

   logic        clk;
   logic        reset;
   logic        stall;
   logic        jump;
   logic [31:0] jump_target;
   logic        branch_taken;
   logic [31:0] branch_target;
   logic [31:0] pc;
   logic [31:0] pc_seq;
   logic        inst_ce;
   logic        misalign_err;
`ifdef PC_TRAP_EN
   logic        trap;
   logic        trap8;
`endif

   logic        reset8;
   logic        stall8;
   logic        jump8;
   logic [7:0]  jump_target8;
   logic        branch_taken8;
   logic [7:0]  branch_target8;
   logic [7:0]  pc8;
   logic [7:0]  pc_seq8;
   logic        inst_ce8;
   logic        misalign_err8;

   int tests_run;
   int tests_failed;

   pc_unit #(.WIDTH(32), .STEP(4), .RESET_ADDR(32'h0), .TRAP_ADDR(32'h0000_0100)) dut (
      .clk           (clk),
      .reset         (reset),
      .stall         (stall),
      .jump          (jump),
      .jump_target   (jump_target),
      .branch_taken  (branch_taken),
      .branch_target (branch_target),
`ifdef PC_TRAP_EN
      .trap          (trap),
`endif
      .pc            (pc),
      .pc_seq        (pc_seq),
      .inst_ce       (inst_ce),
      .misalign_err  (misalign_err)
   );

   pc_unit #(.WIDTH(8), .STEP(4), .RESET_ADDR(8'h00), .TRAP_ADDR(32'h0000_0100)) dut8 (
      .clk           (clk),
      .reset         (reset8),
      .stall         (stall8),
      .jump          (jump8),
      .jump_target   (jump_target8),
      .branch_taken  (branch_taken8),
      .branch_target (branch_target8),
`ifdef PC_TRAP_EN
      .trap          (trap8),
`endif
      .pc            (pc8),
      .pc_seq        (pc_seq8),
      .inst_ce       (inst_ce8),
      .misalign_err  (misalign_err8)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Watchdog so the run always terminates
   initial begin
      #200000;
      $display("FAIL watchdog: run did not finish, got timeout, expected completion");
      $fatal(1, "watchdog");
   end

   // Inputs change and outputs are checked on the falling edge
   task automatic tick();
      @(negedge clk);
   endtask

   task automatic test_reset();
      reset = 1'b1;
      tick();
      tests_run++;
      if (pc !== 32'h0 || inst_ce !== 1'b0 || misalign_err !== 1'b0) begin
         tests_failed++;
         $display("FAIL reset_c1: pc=%h ce=%b mis=%b, expected pc=0 ce=0 mis=0", pc, inst_ce, misalign_err);
      end
      tick();
      tests_run++;
      if (pc !== 32'h0 || inst_ce !== 1'b0) begin
         tests_failed++;
         $display("FAIL reset_c2: pc=%h ce=%b, expected pc=0 ce=0", pc, inst_ce);
      end
   endtask

   task automatic test_boot_increment();
      reset = 1'b0;
      tick();
      tests_run++;
      if (pc !== 32'h0 || inst_ce !== 1'b1) begin
         tests_failed++;
         $display("FAIL boot: pc=%h ce=%b, expected pc=0 ce=1", pc, inst_ce);
      end
      for (int i = 1; i <= 3; i++) begin
         tick();
         tests_run++;
         if (pc !== 32'(4 * i) || inst_ce !== 1'b1) begin
            tests_failed++;
            $display("FAIL incr%0d: pc=%h ce=%b, expected pc=%h ce=1", i, pc, inst_ce, 32'(4 * i));
         end
      end
      tests_run++;
      if (pc_seq !== 32'h10) begin
         tests_failed++;
         $display("FAIL pc_seq: got %h, expected 00000010", pc_seq);
      end
      tick();
      tests_run++;
      if (pc !== 32'h10) begin
         tests_failed++;
         $display("FAIL reach_10: pc=%h, expected 00000010", pc);
      end
   endtask

   task automatic test_stall_pending();
      stall = 1'b1; branch_taken = 1'b1; branch_target = 32'h40;
      tick();
      tests_run++;
      if (pc !== 32'h10 || inst_ce !== 1'b1) begin
         tests_failed++;
         $display("FAIL stall1: pc=%h ce=%b, expected pc=00000010 ce=1", pc, inst_ce);
      end
      branch_taken = 1'b0; jump = 1'b1; jump_target = 32'h80;
      tick();
      tests_run++;
      if (pc !== 32'h10) begin
         tests_failed++;
         $display("FAIL stall2: pc=%h, expected 00000010", pc);
      end
      jump = 1'b0;
      tick();
      tests_run++;
      if (pc !== 32'h10 || misalign_err !== 1'b0) begin
         tests_failed++;
         $display("FAIL stall3: pc=%h mis=%b, expected pc=00000010 mis=0", pc, misalign_err);
      end
      stall = 1'b0;
      tick();
      tests_run++;
      if (pc !== 32'h80) begin
         tests_failed++;
         $display("FAIL pend_load: pc=%h, expected 00000080", pc);
      end
      tick();
      tests_run++;
      if (pc !== 32'h84) begin
         tests_failed++;
         $display("FAIL pend_next: pc=%h, expected 00000084", pc);
      end
   endtask

   task automatic test_jump_branch_priority();
      jump = 1'b1; jump_target = 32'h200; branch_taken = 1'b1; branch_target = 32'h300;
      tick();
      tests_run++;
      if (pc !== 32'h200) begin
         tests_failed++;
         $display("FAIL jump_prio: pc=%h, expected 00000200", pc);
      end
      jump = 1'b0; branch_taken = 1'b0;
      tick();
      tests_run++;
      if (pc !== 32'h204) begin
         tests_failed++;
         $display("FAIL after_prio: pc=%h, expected 00000204", pc);
      end
   endtask

   task automatic test_misalign();
      jump = 1'b1; jump_target = 32'h1006;
      tick();
      tests_run++;
      if (pc !== 32'h1004 || misalign_err !== 1'b1) begin
         tests_failed++;
         $display("FAIL misalign: pc=%h mis=%b, expected pc=00001004 mis=1", pc, misalign_err);
      end
      jump = 1'b0;
      tick();
      tests_run++;
      if (pc !== 32'h1008 || misalign_err !== 1'b0) begin
         tests_failed++;
         $display("FAIL misalign_pulse: pc=%h mis=%b, expected pc=00001008 mis=0", pc, misalign_err);
      end
      // misaligned target captured into the pending slot while stalled
      stall = 1'b1; branch_taken = 1'b1; branch_target = 32'h2003;
      tick();
      tests_run++;
      if (pc !== 32'h1008 || misalign_err !== 1'b1) begin
         tests_failed++;
         $display("FAIL mis_pend: pc=%h mis=%b, expected pc=00001008 mis=1", pc, misalign_err);
      end
      stall = 1'b0; branch_taken = 1'b0;
      tick();
      tests_run++;
      if (pc !== 32'h2000 || misalign_err !== 1'b0) begin
         tests_failed++;
         $display("FAIL mis_pend_load: pc=%h mis=%b, expected pc=00002000 mis=0", pc, misalign_err);
      end
   endtask

   task automatic test_fresh_beats_pending();
      stall = 1'b1; jump = 1'b1; jump_target = 32'h300;
      tick();
      stall = 1'b0; jump = 1'b0; branch_taken = 1'b1; branch_target = 32'h500;
      tick();
      tests_run++;
      if (pc !== 32'h500) begin
         tests_failed++;
         $display("FAIL fresh_redir: pc=%h, expected 00000500", pc);
      end
      branch_taken = 1'b0;
      tick();
      tests_run++;
      if (pc !== 32'h504) begin
         tests_failed++;
         $display("FAIL stale_dropped: pc=%h, expected 00000504", pc);
      end
   endtask

   task automatic test_wrap_and_reset_mid_stall();
      reset8 = 1'b1;
      tick();
      tests_run++;
      if (pc8 !== 8'h00 || inst_ce8 !== 1'b0) begin
         tests_failed++;
         $display("FAIL w8_reset: pc=%h ce=%b, expected pc=00 ce=0", pc8, inst_ce8);
      end
      // redirect and stall during the boot edge are ignored
      reset8 = 1'b0; stall8 = 1'b1; jump8 = 1'b1; jump_target8 = 8'h40;
      tick();
      tests_run++;
      if (pc8 !== 8'h00 || inst_ce8 !== 1'b1) begin
         tests_failed++;
         $display("FAIL w8_boot: pc=%h ce=%b, expected pc=00 ce=1", pc8, inst_ce8);
      end
      stall8 = 1'b0; jump8 = 1'b0;
      tick();
      tests_run++;
      if (pc8 !== 8'h04) begin
         tests_failed++;
         $display("FAIL w8_boot_ignore: pc=%h, expected 04", pc8);
      end
      jump8 = 1'b1; jump_target8 = 8'hFC;
      tick();
      tests_run++;
      if (pc8 !== 8'hFC || pc_seq8 !== 8'h00) begin
         tests_failed++;
         $display("FAIL w8_top: pc=%h seq=%h, expected pc=fc seq=00", pc8, pc_seq8);
      end
      jump8 = 1'b0;
      tick();
      tests_run++;
      if (pc8 !== 8'h00) begin
         tests_failed++;
         $display("FAIL w8_wrap: pc=%h, expected 00", pc8);
      end
      tick();
      stall8 = 1'b1; jump8 = 1'b1; jump_target8 = 8'h20;
      tick();
      tests_run++;
      if (pc8 !== 8'h04) begin
         tests_failed++;
         $display("FAIL w8_stall: pc=%h, expected 04", pc8);
      end
      jump8 = 1'b0; reset8 = 1'b1;
      tick();
      tests_run++;
      if (pc8 !== 8'h00 || inst_ce8 !== 1'b0) begin
         tests_failed++;
         $display("FAIL w8_reset_mid: pc=%h ce=%b, expected pc=00 ce=0", pc8, inst_ce8);
      end
      reset8 = 1'b0; stall8 = 1'b0;
      tick();
      tests_run++;
      if (pc8 !== 8'h00 || inst_ce8 !== 1'b1) begin
         tests_failed++;
         $display("FAIL w8_reboot: pc=%h ce=%b, expected pc=00 ce=1", pc8, inst_ce8);
      end
      for (int i = 1; i <= 2; i++) begin
         tick();
         tests_run++;
         if (pc8 !== 8'(4 * i)) begin
            tests_failed++;
            $display("FAIL w8_no_pend%0d: pc=%h, expected %h", i, pc8, 8'(4 * i));
         end
      end
   endtask

`ifdef PC_TRAP_EN
   task automatic test_trap();
      stall = 1'b1; jump = 1'b1; jump_target = 32'h40; trap = 1'b1;
      tick();
      tests_run++;
      if (pc !== 32'h100 || misalign_err !== 1'b0) begin
         tests_failed++;
         $display("FAIL trap: pc=%h mis=%b, expected pc=00000100 mis=0", pc, misalign_err);
      end
      stall = 1'b0; jump = 1'b0; trap = 1'b0;
      tick();
      tests_run++;
      if (pc !== 32'h104) begin
         tests_failed++;
         $display("FAIL trap_clears_pend: pc=%h, expected 00000104", pc);
      end
   endtask
`endif

   initial begin
      tests_run = 0;
      tests_failed = 0;
      reset = 1'b1; stall = 1'b0; jump = 1'b0; jump_target = '0;
      branch_taken = 1'b0; branch_target = '0;
      reset8 = 1'b1; stall8 = 1'b0; jump8 = 1'b0; jump_target8 = '0;
      branch_taken8 = 1'b0; branch_target8 = '0;
`ifdef PC_TRAP_EN
      trap = 1'b0;
      trap8 = 1'b0;
`endif
      test_reset();
      test_boot_increment();
      test_stall_pending();
      test_jump_branch_priority();
      test_misalign();
      test_fresh_beats_pending();
      test_wrap_and_reset_mid_stall();
`ifdef PC_TRAP_EN
      test_trap();
`endif
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule

// File: doc/pc_unit.md
Name: pc_unit

Overview:
- Parametrised program-counter unit; successor to the fixed 32-bit, always-increment PC.
- Sits at the front of the CPU fetch path and drives the instruction-memory address and its chip enable.
- Adds:
  - configurable width, step and reset address
  - stall hold
  - jump and branch redirect with fixed priority
  - redirect buffering while stalled
  - target alignment checking
  - registered, zero-lag PC: the issued address equals the internal PC, with no one-cycle shadow copy

Parameters:
- WIDTH, 32: PC and target width in bits.
- STEP, 4: sequential increment in bytes; must be a power of two, at least 1.
- RESET_ADDR, 0: PC value loaded on reset.
- TRAP_ADDR, 32'h0000_0100: trap vector, truncated to WIDTH. Used only with PC_TRAP_EN.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- stall  in  1  hold PC this cycle.
- jump  in  1  unconditional redirect request.
- jump_target  in  WIDTH  jump destination.
- branch_taken  in  1  taken-branch redirect request.
- branch_target  in  WIDTH  branch destination.
- pc  out  WIDTH  current fetch address (registered).
- pc_seq  out  WIDTH  pc + STEP modulo 2^WIDTH (combinational from pc).
- inst_ce  out  1  instruction-memory enable (registered).
- misalign_err  out  1  one-cycle pulse: last accepted target had nonzero low bits (registered).
- trap  in  1  trap request; present only with PC_TRAP_EN.

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high on port reset. Reset has priority over every other input.
- Reset values:
  - pc = RESET_ADDR
  - inst_ce = 0
  - misalign_err = 0
  - pend_valid = 0, pend_target = 0
- Boot sequence:
  - First edge with reset=0: inst_ce <= 1, pc holds RESET_ADDR, so RESET_ADDR is fetched first.
  - pc never advances on an edge where inst_ce was 0.
- Define ALIGN = log2(STEP).
  - Each accepted target has its low ALIGN bits forced to 0.
  - misalign_err <= 1 on the edge a target with nonzero low bits is loaded into pc or pend_target; otherwise misalign_err <= 0.
- Redirect select:
  - redir = jump | branch_taken.
  - If both are asserted, jump wins: rtgt = jump_target, else branch_target.
- Next-state rules at each edge with reset=0 and inst_ce=1, highest priority first:
  1. stall=1 and redir=1: pc holds; pend_valid <= 1; pend_target <= aligned rtgt. A later redirect during the same stall overwrites the pending target.
  2. stall=1 and redir=0: pc and pending state hold.
  3. stall=0 and redir=1: pc <= aligned rtgt; pend_valid <= 0. A fresh redirect beats a stale pending one.
  4. stall=0 and pend_valid=1: pc <= pend_target; pend_valid <= 0.
  5. Otherwise: pc <= pc + STEP, wrapping modulo 2^WIDTH.
- inst_ce behaviour:
  - Stays 1 after boot until the next reset.
  - inst_ce is not dropped during stall; memory re-reads the same address.
- Timing: a redirect takes effect on pc the cycle after it is sampled (latency 1), unless stalled.
- Wrap-around: pc = 2^WIDTH − STEP with stall=0 gives pc = 0 next.
- Reset mid-operation, including mid-stall with a pending target: pending state is discarded and the boot sequence repeats.
- Ignored inputs: stall and redirect inputs are ignored while reset=1 or inst_ce=0. During boot no pending capture occurs.

Optional Feature:
- Macro: PC_TRAP_EN.
- Defined:
  - Adds the trap input.
  - trap=1 on an edge with reset=0 and inst_ce=1 gives pc <= TRAP_ADDR (aligned) and pend_valid <= 0.
  - trap has priority over stall, jump and branch.
  - misalign_err follows the alignment rule for TRAP_ADDR.
- Undefined: no trap port, no trap logic; behaviour is exactly as above.

Test Plan:
- Boot and increment: reset=1 for 2 cycles, then release, WIDTH=32, STEP=4, RESET_ADDR=0.
  - inst_ce: 0, 0, then 1.
  - pc: 0, 0, 0, 4, 8, 12 on successive cycles.
- Stall plus pending redirect: pc=0x10; stall=1 for 3 cycles; branch_taken=1, branch_target=0x40 in stall cycle 1; jump=1, jump_target=0x80 in stall cycle 2.
  - pc stays 0x10 throughout the stall.
  - After stall drops: pc = 0x80, then 0x84.
- Simultaneous jump and branch: jump_target=0x200 and branch_target=0x300 in the same unstalled cycle.
  - pc = 0x200 next cycle.
- Misaligned target: jump_target=0x1006, STEP=4.
  - pc = 0x1004, misalign_err high for exactly 1 cycle, then pc = 0x1008.
- Wrap and reset mid-stall:
  - WIDTH=8, pc=0xFC, no stall: pc = 0x00 next.
  - Stall with pending target 0x20, then reset=1: after reset pc = RESET_ADDR and 0x20 is never loaded.
- With PC_TRAP_EN: stall=1, jump=1 (target 0x40) and trap=1 in the same cycle.
  - pc = 0x100 next cycle.
  - Pending state is cleared: after stall drops, pc = 0x104.
